// File: rtl/cmp_result_collector.sv
// Collector for the pipelined 4-bit magnitude comparator: tags flags with their issue,
// checks one-hot encoding, keeps saturating statistics and serves snapshots via req/ack.
module cmp_result_collector #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             A_greater,
    input  logic             A_equal,
    input  logic             A_less,
    input  logic             clear,
    output logic             result_valid,
    output logic [1:0]       result_code,
    output logic             onehot_err,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ack,
    output logic [CNT_W-1:0] snap_gt,
    output logic [CNT_W-1:0] snap_eq,
    output logic [CNT_W-1:0] snap_lt,
    output logic [CNT_W-1:0] snap_err,
    output logic [CNT_W-1:0] snap_total
);

    typedef enum logic {S_IDLE, S_HOLD} snap_state_e;

    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic               sample;
    logic [1:0]         code;
    logic               malformed;

    logic [CNT_W-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d, total_q, total_d;
    logic             oh_q, oh_d;
    logic             rv_q, rv_d;
    logic [1:0]       rc_q, rc_d;

    snap_state_e      state_q, state_d;
    logic [CNT_W-1:0] sgt_q, sgt_d, seq_q, seq_d, slt_q, slt_d, serr_q, serr_d, stot_q, stot_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        vpipe_d    = vpipe_q;
        vpipe_d[0] = issue_valid;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    assign sample = vpipe_q[LATENCY-1];

    always_comb begin
        code      = 2'b00;
        malformed = 1'b1;
        case ({A_greater, A_equal, A_less})
            3'b100:  begin code = 2'b01; malformed = 1'b0; end
            3'b010:  begin code = 2'b10; malformed = 1'b0; end
            3'b001:  begin code = 2'b11; malformed = 1'b0; end
            default: ;
        endcase
    end

    // clear wins over a same-cycle sample; the result pulse is still emitted
    always_comb begin
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        err_d   = err_q;
        total_d = total_q;
        oh_d    = oh_q;
        rv_d    = sample;
        rc_d    = sample ? code : 2'b00;
        if (clear) begin
            gt_d    = '0;
            eq_d    = '0;
            lt_d    = '0;
            err_d   = '0;
            total_d = '0;
            oh_d    = 1'b0;
        end else if (sample) begin
            total_d = sat_inc(total_q);
            case (code)
                2'b01:   gt_d = sat_inc(gt_q);
                2'b10:   eq_d = sat_inc(eq_q);
                2'b11:   lt_d = sat_inc(lt_q);
                default: begin
                    err_d = sat_inc(err_q);
                    oh_d  = malformed;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        sgt_d   = sgt_q;
        seq_d   = seq_q;
        slt_d   = slt_q;
        serr_d  = serr_q;
        stot_d  = stot_q;
        case (state_q)
            S_IDLE: if (snap_req) begin
                state_d = S_HOLD;
                sgt_d   = gt_q;
                seq_d   = eq_q;
                slt_d   = lt_q;
                serr_d  = err_q;
                stot_d  = total_q;
            end
            S_HOLD: if (snap_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q <= '0;
            gt_q    <= '0;
            eq_q    <= '0;
            lt_q    <= '0;
            err_q   <= '0;
            total_q <= '0;
            oh_q    <= 1'b0;
            rv_q    <= 1'b0;
            rc_q    <= 2'b00;
            state_q <= S_IDLE;
            sgt_q   <= '0;
            seq_q   <= '0;
            slt_q   <= '0;
            serr_q  <= '0;
            stot_q  <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
            total_q <= total_d;
            oh_q    <= oh_d;
            rv_q    <= rv_d;
            rc_q    <= rc_d;
            state_q <= state_d;
            sgt_q   <= sgt_d;
            seq_q   <= seq_d;
            slt_q   <= slt_d;
            serr_q  <= serr_d;
            stot_q  <= stot_d;
        end
    end

    assign result_valid = rv_q;
    assign result_code  = rc_q;
    assign onehot_err   = oh_q;
    assign snap_valid   = (state_q == S_HOLD);
    assign snap_gt      = sgt_q;
    assign snap_eq      = seq_q;
    assign snap_lt      = slt_q;
    assign snap_err     = serr_q;
    assign snap_total   = stot_q;

endmodule
